button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Front-end for the four colour buttons and the start button of the Genius game, feeding the game core.
//  - Synchronises and debounces all five raw inputs.
//  - Turns each colour press into one 2-bit colour code, offered on a valid/ready handshake.
//  - Turns each start press into a one-cycle start pulse.
//  - The game core consumes player_button/press_valid; the board pins drive the raw inputs.
// PARAMETERS
//  COLOR_CODEFY_W   2   width of a colour code (from typedefs_pkg)
//  DEBOUNCE_CYCLES  4   consecutive stable cycles needed to accept a level change (>=2; board build uses 500000)
//  DEBOUNCE_W       20  width of the debounce counter; must hold DEBOUNCE_CYCLES-1
//  FIFO_DEPTH       4   press buffer depth, power of 2; used only with BTN_PRESS_FIFO_EN
// PORTS
//  clk               input   1               system clock
//  rst               input   1               synchronous reset, active-high
//  btn_red_raw       input   1               raw red button, async, active-high
//  btn_green_raw     input   1               raw green button
//  btn_blue_raw      input   1               raw blue button
//  btn_yellow_raw    input   1               raw yellow button
//  btn_start_raw     input   1               raw start button
//  player_button     output  COLOR_CODEFY_W  colour code of the offered press (RED=0 GREEN=1 BLUE=2 YELLOW=3)
//  press_valid       output  1               a press is offered
//  press_ready       input   1               consumer accepts; transfer happens when valid&&ready
//  start_pulse       output  1               one-cycle pulse on each debounced start press
//  multi_press       output  1               one-cycle pulse: more than one colour rose in the same cycle
//  overflow          output  1               one-cycle pulse: a press was dropped because the buffer was full
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge):
//    - All synchroniser flops, stable levels and counters clear to 0.
//    - All outputs are 0; the buffer is emptied.
//    - Reset wins over every other event, including mid-debounce and mid-handshake.
//  - Synchroniser: two flops per input; sync_q2 lags raw by 2 cycles.
//  - Debounce, per input:
//    - While sync_q2 == stable: cnt = 0.
//    - While they differ: cnt increments.
//    - If they differ and cnt == DEBOUNCE_CYCLES-1: stable <= sync_q2 and cnt <= 0.
//    - A glitch shorter than DEBOUNCE_CYCLES resets cnt and never changes stable.
//  - Latency:
//    - A raw rise held steady gives stable=1 at cycle 2+DEBOUNCE_CYCLES.
//    - Its event is registered at cycle 3+DEBOUNCE_CYCLES.
//  - Events:
//    - An event is the rising edge of stable (stable & ~stable_d). Falling edges produce nothing.
//    - Holding a button down gives exactly one event.
//  - Colour priority: if several colour events occur in the same cycle, the lowest code wins, the rest are discarded, and multi_press pulses.
//  - Start: a start event drives start_pulse=1 for exactly one cycle. It is independent of colours and of the handshake.
//  - Handshake:
//    - press_valid and player_button are registered.
//    - Once press_valid=1, player_button is held stable until the cycle after valid&&ready.
//    - press_valid does not depend combinationally on press_ready.
//  - Buffer (no FIFO):
//    - Single holding register with two states, EMPTY and FULL.
//    - EMPTY + event -> FULL.
//    - FULL + valid&&ready, no event -> EMPTY.
//    - FULL + valid&&ready + event in the same cycle -> stays FULL with the new code. Nothing is lost.
//    - FULL + event, no transfer -> the new press is dropped, overflow pulses, the held code is unchanged.
// CONFIGURATION
//  BTN_PRESS_FIFO_EN, when defined:
//    - The holding register becomes a FIFO_DEPTH-entry FIFO with write/read pointers one bit wider than log2(FIFO_DEPTH); pointers wrap around.
//    - press_valid = not empty; player_button = head entry.
//    - A push and a pop in the same cycle are both honoured, including when the FIFO is full.
//    - overflow pulses only when the FIFO is full, an event arrives and there is no pop.
//  BTN_PRESS_FIFO_EN undefined: single-register behaviour above; FIFO_DEPTH is ignored.
// STRUCTURE
//  - typedefs_pkg gains:
//    - color_e enum: RED=0, GREEN=1, BLUE=2, YELLOW=3.
//    - the default for DEBOUNCE_CYCLES.
//    - COLOR_CODEFY_W already lives there.
//  - Sub-module button_debouncer (param DEBOUNCE_CYCLES, DEBOUNCE_W):
//    - Ports: clk, rst, raw -> stable, rise.
//    - Instantiated five times.
//  - Priority encoder, buffer/FIFO and pulse logic live in button_conditioner itself.
// TESTING (DEBOUNCE_CYCLES=4, press_ready=1 unless stated)
//  1. Green press: raw rise at cycle 0, held 20 cycles
//     -> press_valid=1, player_button=1 at cycle 7, for one cycle; no further event while held.
//  2. Glitch: blue high 3 cycles, then low -> no press_valid, no multi_press.
//  3. Red and yellow rise on the same edge
//     -> player_button=0 (red) once; multi_press=1 in that same cycle; no yellow press.
//  4. Backpressure, press_ready=0: red press, then blue press
//     -> red held; overflow=1 for one cycle on the blue event.
//     -> Raising press_ready transfers red; press_valid drops the next cycle.
//  5. Start: start held 10 cycles -> start_pulse=1 for exactly one cycle (cycle 7).
//     Then rst asserted mid-debounce of a yellow press -> all outputs 0, no yellow press after release of rst.
//  6. FIFO build, press_ready=0:
//     - Five presses (codes 0,1,2,3,0) -> fifth raises overflow.
//     - Raising press_ready then pops 0,1,2,3 in order, one per cycle.
//     - A push during a full pop is retained.

Source files
------------

// File: rtl/typedefs_pkg.sv
// Shared types and defaults for the Genius game front-end.
// Colour codes, buffer states and the colour priority helper live here.
package typedefs_pkg;

  localparam int unsigned COLOR_CODEFY_W      = 2;
  localparam int unsigned NUM_COLORS          = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned DEBOUNCE_W_DEF      = 20;
  localparam int unsigned FIFO_DEPTH_DEF      = 4;

  typedef enum logic [COLOR_CODEFY_W-1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } color_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  // Lowest code wins when several colours rise together.
  function automatic color_e lowest_color(input logic [NUM_COLORS-1:0] rises);
    color_e c;
    c = RED;
    for (int i = NUM_COLORS - 1; i >= 0; i--) begin
      if (rises[i]) c = color_e'(COLOR_CODEFY_W'(i));
    end
    return c;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stable-level debouncer for one raw button.
// rise is a combinational one-cycle strobe on each accepted low-to-high change.
module button_debouncer
  import typedefs_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned DEBOUNCE_W      = DEBOUNCE_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

  logic                  sync_q1;
  logic                  sync_q2;
  logic                  stable_d;
  logic [DEBOUNCE_W-1:0] cnt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync_q1  <= raw;
      sync_q2  <= sync_q1;
      stable_d <= stable;
      if (sync_q2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_q2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = stable & ~stable_d;

endmodule

// File: rtl/button_conditioner.sv
// Debounces the four colour buttons and start, offers colour presses on valid/ready.
// Define BTN_PRESS_FIFO_EN to replace the single holding register with a FIFO.
module button_conditioner
  import typedefs_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned DEBOUNCE_W      = DEBOUNCE_W_DEF
`ifdef BTN_PRESS_FIFO_EN
  ,
  parameter int unsigned FIFO_DEPTH      = FIFO_DEPTH_DEF
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      btn_red_raw,
  input  logic                      btn_green_raw,
  input  logic                      btn_blue_raw,
  input  logic                      btn_yellow_raw,
  input  logic                      btn_start_raw,
  output logic [COLOR_CODEFY_W-1:0] player_button,
  output logic                      press_valid,
  input  logic                      press_ready,
  output logic                      start_pulse,
  output logic                      multi_press,
  output logic                      overflow
);

  // Index order matches the colour codes; start sits on top.
  logic [4:0]            raw_vec;
  logic [4:0]            rise_vec;
  logic [4:0]            stable_levels_unused;
  logic [NUM_COLORS-1:0] color_rise;
  logic                  ev;
  logic                  multi_c;
  color_e                ev_code;
  logic                  pop;
  logic                  ovf_nxt;

  assign raw_vec = {btn_start_raw, btn_yellow_raw, btn_blue_raw, btn_green_raw, btn_red_raw};

  for (genvar i = 0; i < 5; i++) begin : g_deb
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DEBOUNCE_W     (DEBOUNCE_W)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_vec[i]),
      .stable(stable_levels_unused[i]),
      .rise  (rise_vec[i])
    );
  end

  assign color_rise = rise_vec[NUM_COLORS-1:0];
  assign ev         = |color_rise;
  assign ev_code    = lowest_color(color_rise);
  assign multi_c    = (color_rise & (color_rise - 1'b1)) != '0;
  assign pop        = press_valid & press_ready;

`ifdef BTN_PRESS_FIFO_EN
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] PTR_WRAP = {1'b1, {AW{1'b0}}};

  color_e           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr ^ rd_ptr) == PTR_WRAP);
  // A pop frees the slot this same edge, so a full FIFO still takes the push.
  assign push    = ev & (~full | pop);
  assign ovf_nxt = ev & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is left unreset; the empty flag masks stale entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= ev_code;
  end

  assign press_valid   = ~empty;
  assign player_button = empty ? '0 : mem[rd_ptr[AW-1:0]];
`else
  buf_state_e state;
  buf_state_e state_nxt;
  color_e     held_code;
  color_e     held_code_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      held_code <= RED;
    end else begin
      state     <= state_nxt;
      held_code <= held_code_nxt;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    held_code_nxt = held_code;
    ovf_nxt       = 1'b0;
    case (state)
      EMPTY: begin
        if (ev) begin
          state_nxt     = FULL;
          held_code_nxt = ev_code;
        end
      end
      FULL: begin
        if (pop && ev) begin
          held_code_nxt = ev_code;
        end else if (pop) begin
          state_nxt = EMPTY;
        end else if (ev) begin
          ovf_nxt = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign press_valid   = (state == FULL);
  assign player_button = held_code;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      start_pulse <= 1'b0;
      multi_press <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      start_pulse <= rise_vec[4];
      multi_press <= multi_c;
      overflow    <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner with a scoreboard
// fed by a steady-run behavioural model of the button front-end.
module tb_button_conditioner;

  localparam int N = 4;
`ifdef BTN_PRESS_FIFO_EN
  localparam int MDL_DEPTH = 4;
`else
  localparam int MDL_DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] raw = '0;   // red, green, blue, yellow, start
  logic       press_ready = 1'b1;
  logic [1:0] player_button;
  logic       press_valid;
  logic       start_pulse;
  logic       multi_press;
  logic       overflow;

  always #5 clk = ~clk;

  button_conditioner dut (
    .clk           (clk),
    .rst           (rst),
    .btn_red_raw   (raw[0]),
    .btn_green_raw (raw[1]),
    .btn_blue_raw  (raw[2]),
    .btn_yellow_raw(raw[3]),
    .btn_start_raw (raw[4]),
    .player_button (player_button),
    .press_valid   (press_valid),
    .press_ready   (press_ready),
    .start_pulse   (start_pulse),
    .multi_press   (multi_press),
    .overflow      (overflow)
  );

  typedef struct packed {
    logic       valid;
    logic [1:0] code;
    logic       start;
    logic       multi;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   dut_xfers = 0;
  int   mdl_xfers = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  // Reference model: a button level is accepted once the twice-delayed
  // input has shown the same value for N samples in a row.
  bit [1:0] dly [5];
  bit       last_d [5];
  int       run_len [5];
  bit [4:0] mdl_stable;
  bit [4:0] mdl_rise;
  int       mdl_buf[$];

  always @(posedge clk) begin
    exp_t     e;
    bit [3:0] crise;
    bit       d;
    bit       nxt;
    int       code;
    e = '0;
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        dly[i] = 2'b00;
        run_len[i] = 0;
        last_d[i] = 1'b0;
      end
      mdl_stable = '0;
      mdl_rise   = '0;
      mdl_buf.delete();
    end else begin
      crise = mdl_rise[3:0];
      if (mdl_buf.size() > 0 && press_ready) begin
        void'(mdl_buf.pop_front());
        mdl_xfers++;
      end
      if (crise != 4'd0) begin
        code = 0;
        for (int i = 3; i >= 0; i--) if (crise[i]) code = i;
        if (mdl_buf.size() < MDL_DEPTH) mdl_buf.push_back(code);
        else e.ovf = 1'b1;
      end
      e.start = mdl_rise[4];
      e.multi = ($countones(crise) > 1);
      for (int i = 0; i < 5; i++) begin
        d = dly[i][1];
        dly[i] = {dly[i][0], raw[i]};
        if (run_len[i] > 0 && d == last_d[i]) run_len[i]++;
        else run_len[i] = 1;
        last_d[i] = d;
        nxt = (run_len[i] >= N && d != mdl_stable[i]) ? d : mdl_stable[i];
        mdl_rise[i]   = nxt & ~mdl_stable[i];
        mdl_stable[i] = nxt;
      end
    end
    e.valid = (mdl_buf.size() > 0);
    e.code  = e.valid ? 2'(mdl_buf[0]) : 2'd0;
    exp_q.push_back(e);
  end

  // Monitor: one expected record per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("press_valid", 32'(press_valid), 32'(e.valid));
      if (e.valid) check("player_button", 32'(player_button), 32'(e.code));
      check("start_pulse", 32'(start_pulse), 32'(e.start));
      check("multi_press", 32'(multi_press), 32'(e.multi));
      check("overflow", 32'(overflow), 32'(e.ovf));
      if (press_valid === 1'b1 && press_ready === 1'b1) dut_xfers++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input int idx, input int hold, input int gap);
    raw[idx] = 1'b1;
    tick(hold);
    raw[idx] = 1'b0;
    tick(gap);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick(2);

    // Single green press held for a long time.
    press(1, 20, 10);
    // Short blue glitch.
    press(2, 3, 10);
    // Red and yellow together.
    raw[0] = 1'b1; raw[3] = 1'b1;
    tick(10);
    raw[0] = 1'b0; raw[3] = 1'b0;
    tick(10);
    // Backpressure: red held, blue dropped, then release.
    press_ready = 1'b0;
    press(0, 8, 4);
    press(2, 8, 6);
    press_ready = 1'b1;
    tick(5);
    // Start press.
    press(4, 10, 8);
    // Reset during a yellow debounce.
    raw[3] = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    raw[3] = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(12);
    // Fill the buffer, then drain while pressing again.
    press_ready = 1'b0;
    press(0, 6, 6);
    press(1, 6, 6);
    press(2, 6, 6);
    press(3, 6, 6);
    press(0, 6, 6);
    press_ready = 1'b1;
    tick(1);
    press(1, 6, 10);

    // Random stimulus with glitches, overlaps, backpressure and resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(0, 11) == 0) raw[i] = ~raw[i];
      end
      press_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    rst = 1'b0;
    raw = '0;
    press_ready = 1'b1;
    tick(20);

    check("transfer_count", 32'(dut_xfers), 32'(mdl_xfers));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
